piso_tx_ctrl: RTL and testbench
===============================

# piso_tx_ctrl

Serial transmit controller that owns a WIDTH-bit parallel-in/serial-out shift register. It accepts parallel words from one upstream requester over a valid/ready handshake and loads the register. It then shifts each word out MSB-first at a programmable bit rate, inserts a configurable idle gap between words, and flags the first bit, the last bit and word completion for downstream framing logic.

## Interface
- WIDTH, 4: word width in bits; must be ≥2.
- DIV, 1: clk cycles per serial bit; must be ≥1.
- GAP, 0: idle bit periods inserted after each word; must be ≥0.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  WIDTH  parallel word; sampled only on acceptance.
- in_valid  in  1  requester has a word.
- in_ready  out  1  controller can accept; equals (state == IDLE).
- ser_out  out  1  serial data; MSB first.
- ser_valid  out  1  ser_out carries a data bit.
- ser_first  out  1  high for the whole first bit period of a word.
- ser_last  out  1  high for the whole last bit period of a word.
- busy  out  1  high in SHIFT or GAP.
- done  out  1  one-cycle pulse when a word has fully shifted out.

## Operation
- States are IDLE, SHIFT and GAP. The reset state is IDLE.
- Acceptance occurs on an edge where in_valid && in_ready. At that edge:
  - sreg <= in_data
  - bit_cnt <= WIDTH-1
  - div_cnt <= DIV-1
  - state <= SHIFT
- SHIFT:
  - Outputs: ser_out = sreg[WIDTH-1], ser_valid = 1.
  - div_cnt decrements each cycle. A tick is div_cnt == 0.
  - On a tick with bit_cnt ≠ 0: sreg shifts left one place with 0 filled in, bit_cnt decrements, div_cnt reloads to DIV-1.
  - On a tick with bit_cnt == 0: done is set for the next cycle. The next state is GAP if GAP > 0, otherwise IDLE.
- GAP:
  - Outputs: ser_out = 0, ser_valid = 0.
  - Remains in GAP for exactly GAP*DIV cycles, then returns to IDLE.
- ser_first = SHIFT && bit_cnt == WIDTH-1.
- ser_last = SHIFT && bit_cnt == 0.
- In IDLE, ser_out is 0 and ser_valid is 0.
- Holding in_valid while in_ready = 0 has no effect. Changes to in_data while busy are ignored.
- rst has priority over acceptance and all transitions. After a reset asserted mid-word, the word is discarded and no done pulse is produced.
- Counters are sized $clog2(WIDTH) and $clog2(max(DIV, GAP*DIV)+1). Counters never wrap: every reload happens explicitly at a tick.

## Timing
- Reset values:
  - ser_out, ser_valid, ser_first, ser_last, busy, done: 0.
  - in_ready: 1 (IDLE).
  - sreg and counters: 0.
- Let k be the acceptance cycle, i.e. in_valid && in_ready is sampled at the end of cycle k.
- Data bits: bit i (MSB = bit 0) is on ser_out during cycles k+1+i*DIV through k+(i+1)*DIV.
- ser_valid is high in cycles k+1 through k+WIDTH*DIV.
- done is high only in cycle k+WIDTH*DIV+1.
- If GAP = 0: in_ready is high again in cycle k+WIDTH*DIV+1.
- If GAP > 0: GAP occupies cycles k+WIDTH*DIV+1 through k+WIDTH*DIV+GAP*DIV, and in_ready is high again in cycle k+(WIDTH+GAP)*DIV+1.
- The minimum spacing between accepted words is (WIDTH+GAP)*DIV+1 cycles.
- A new word can be accepted in the same cycle done is high, which is the GAP = 0 case.
- Latency from acceptance to the first bit is 1 cycle.

## Structure
- Shared package piso_ctrl_pkg holds:
  - the state encoding constants ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_GAP = 2'd2;
  - the counter-width helper function.
- Sub-module piso_shreg: a WIDTH-bit register with a synchronous parallel load and a shift-left enable. Its serial output is its MSB.
  - piso_tx_ctrl drives load = acceptance and shift = a tick with bit_cnt ≠ 0.
- The FSM, the counters and the output decode stay in piso_tx_ctrl.

## Test plan
- WIDTH=4, DIV=1, GAP=0. Send 4'b1011 at cycle k.
  - Required: ser_out = 1,0,1,1 in cycles k+1 to k+4; ser_first high at k+1; ser_last high at k+4; done and in_ready high at k+5.
- Back-to-back traffic, 4'b1100 then 4'b0011, with in_valid held high.
  - Required: the second word is accepted in the done cycle; the serial stream is 1100 0011 with exactly one non-valid cycle between the words.
- WIDTH=4, DIV=3. Send 4'b1001.
  - Required: each bit is held 3 cycles; ser_valid is high for 12 cycles; done is high at k+13.
- WIDTH=4, DIV=1, GAP=2. Send 4'b1111.
  - Required: done is high at k+5; ser_valid is 0 and in_ready is 0 in cycles k+5 and k+6; in_ready is 1 at k+7.
- Assert rst for one cycle during the bit-2 period of 4'b1010.
  - Required: all outputs are at reset values the next cycle; no done pulse occurs; the next word serializes correctly.
- Toggle in_valid and in_data while busy.
  - Required: no extra acceptance, and the in-flight bits are unchanged.

Source files
------------

// File: rtl/piso_tx_ctrl_pkg.sv
// piso_ctrl_pkg
// Shared definitions for the serial transmit controller:
//   state_t    - FSM state encoding (IDLE / SHIFT / GAP)
//   cnt_width  - width of the divider/gap counter for a DIV/GAP pair
package piso_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // One counter serves both the bit-period divider and the idle gap,
    // so it must hold the larger of DIV and GAP*DIV.
    function automatic int cnt_width(input int div, input int gap);
        int m;
        m = (gap * div > div) ? gap * div : div;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/piso_tx_ctrl_if.sv
// piso_tx_ctrl_if
// Bundle between an upstream requester and the serial transmit controller,
// plus the serial side seen by downstream framing logic.
//
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready
// are both high. in_data is sampled only on that edge. The requester may hold
// or drop in_valid freely; while in_ready is low nothing is consumed.
//
//   in_data   requester -> ctrl  parallel word
//   in_valid  requester -> ctrl  word available
//   in_ready  ctrl -> requester  controller idle, can accept
//   ser_out   ctrl -> downstream serial data, MSB first
//   ser_valid ctrl -> downstream ser_out carries a data bit
//   ser_first ctrl -> downstream first bit period of a word
//   ser_last  ctrl -> downstream last bit period of a word
//   busy      ctrl -> downstream shifting or in idle gap
//   done      ctrl -> downstream one-cycle pulse after the last bit
interface piso_tx_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             busy;
    logic             done;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, ser_valid, ser_first, ser_last, busy, done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, ser_valid, ser_first, ser_last, busy, done
    );
endinterface

// File: rtl/piso_tx_ctrl_shreg.sv
// piso_shreg
// WIDTH-bit parallel-in/serial-out register.
//   clk, rst : clock, synchronous active-high reset (clears to 0)
//   load     : load d (has priority over shift)
//   shift    : shift left one place, 0 filled in at the LSB
//   d        : parallel word
//   q_msb    : serial output (current MSB)
module piso_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_msb
);
    logic [WIDTH-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= d;
        end else if (shift) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign q_msb = sreg[WIDTH-1];
endmodule

// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl
// Serial transmit controller: accepts a WIDTH-bit word over valid/ready,
// shifts it out MSB first with DIV clk cycles per bit, then idles for
// GAP bit periods before accepting the next word.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : handshake + serial outputs (slave side of piso_tx_ctrl_if)
//   state_dbg : current FSM state, for observation only
module piso_tx_ctrl
    import piso_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1,
    parameter int GAP   = 0
) (
    input  logic   clk,
    input  logic   rst,
    piso_tx_ctrl_if.slave bus,
    output state_t state_dbg
);
    localparam int BW = $clog2(WIDTH);
    localparam int CW = cnt_width(DIV, GAP);

    localparam logic [BW-1:0] BIT_TOP    = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE    = BW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] DIV_RELOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_RELOAD = CW'(GAP * DIV - 1);

    state_t        state;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] div_cnt;
    logic          done_q;
    logic          accept;
    logic          tick;
    logic          shift_en;
    logic          sreg_msb;

    assign accept   = (state == ST_IDLE) && bus.in_valid;
    assign tick     = (div_cnt == '0);
    assign shift_en = (state == ST_SHIFT) && tick && (bit_cnt != '0);

    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift_en),
        .d     (bus.in_data),
        .q_msb (sreg_msb)
    );

    // div_cnt doubles as the gap timer: it is reloaded with GAP*DIV-1 on
    // leaving SHIFT so GAP lasts exactly GAP*DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            div_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        bit_cnt <= BIT_TOP;
                        div_cnt <= DIV_RELOAD;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!tick) begin
                        div_cnt <= div_cnt - CNT_ONE;
                    end else if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - BIT_ONE;
                        div_cnt <= DIV_RELOAD;
                    end else begin
                        done_q <= 1'b1;
                        if (GAP > 0) begin
                            div_cnt <= GAP_RELOAD;
                            state   <= ST_GAP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (!tick) begin
                        div_cnt <= div_cnt - CNT_ONE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The register keeps its last bit after the word, so gate it with SHIFT.
    assign bus.ser_out   = (state == ST_SHIFT) && sreg_msb;
    assign bus.ser_valid = (state == ST_SHIFT);
    assign bus.ser_first = (state == ST_SHIFT) && (bit_cnt == BIT_TOP);
    assign bus.ser_last  = (state == ST_SHIFT) && (bit_cnt == '0);
    assign bus.busy      = (state == ST_SHIFT) || (state == ST_GAP);
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.done      = done_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl. Three instances share clk/rst:
//   u0: DIV=1 GAP=0, u1: DIV=3 GAP=0, u2: DIV=1 GAP=2 (all WIDTH=4).
// Only the selected instance sees in_valid; expected per-cycle output
// vectors {in_ready, ser_out, ser_valid, ser_first, ser_last, busy, done}
// are built from the bit-timing rules when a word is accepted.
module tb_piso_tx_ctrl;
    import piso_ctrl_pkg::*;

    localparam logic [6:0] IDLE_V = 7'b1000000;

    logic clk;
    logic rst;
    state_t st_v [3];

    piso_tx_ctrl_if #(.WIDTH(4)) b0 ();
    piso_tx_ctrl_if #(.WIDTH(4)) b1 ();
    piso_tx_ctrl_if #(.WIDTH(4)) b2 ();

    piso_tx_ctrl #(.WIDTH(4), .DIV(1), .GAP(0)) u0 (.clk(clk), .rst(rst), .bus(b0), .state_dbg(st_v[0]));
    piso_tx_ctrl #(.WIDTH(4), .DIV(3), .GAP(0)) u1 (.clk(clk), .rst(rst), .bus(b1), .state_dbg(st_v[1]));
    piso_tx_ctrl #(.WIDTH(4), .DIV(1), .GAP(2)) u2 (.clk(clk), .rst(rst), .bus(b2), .state_dbg(st_v[2]));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         sel;
    logic [6:0] obs_v [3];
    logic [6:0] obs;

    always_comb begin
        obs_v[0] = {b0.in_ready, b0.ser_out, b0.ser_valid, b0.ser_first, b0.ser_last, b0.busy, b0.done};
        obs_v[1] = {b1.in_ready, b1.ser_out, b1.ser_valid, b1.ser_first, b1.ser_last, b1.busy, b1.done};
        obs_v[2] = {b2.in_ready, b2.ser_out, b2.ser_valid, b2.ser_first, b2.ser_last, b2.busy, b2.done};
        obs      = obs_v[0];
        if (sel == 1) obs = obs_v[1];
        if (sel == 2) obs = obs_v[2];
    end

    // scoreboard
    logic [6:0] exp_q[$];
    logic       exp_ready;
    logic       last_acc;
    int         n_vec;
    int         n_err;

    function automatic int div_of(input int s);
        return (s == 1) ? 3 : 1;
    endfunction

    function automatic int gap_of(input int s);
        return (s == 2) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (dut %0d, t=%0t): got %b expected %b [rdy,out,vld,first,last,busy,done]",
                     name, sel, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s (dut %0d, t=%0t): got %0d expected %0d", name, sel, $time, got, exp);
        end
    endtask

    // Expected vectors for every cycle from acceptance+1 to the end of GAP.
    task automatic push_word(input logic [3:0] d);
        int dv;
        int gp;
        dv = div_of(sel);
        gp = gap_of(sel);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < dv; j++) begin
                exp_q.push_back({1'b0, d[3-i], 1'b1, (i == 0), (i == 3), 1'b1, 1'b0});
            end
        end
        if (gp == 0) begin
            exp_q.push_back(7'b1000001);
        end else begin
            exp_q.push_back(7'b0000011);
            for (int j = 1; j < gp * dv; j++) exp_q.push_back(7'b0000010);
        end
    endtask

    // driver: one clock cycle with the given inputs, then check the next cycle
    task automatic step(input logic v, input logic [3:0] d);
        logic [6:0] e;
        b0.in_valid = v && (sel == 0);
        b1.in_valid = v && (sel == 1);
        b2.in_valid = v && (sel == 2);
        b0.in_data  = d;
        b1.in_data  = d;
        b2.in_data  = d;
        last_acc = v && exp_ready;
        if (last_acc) push_word(d);
        if (exp_q.size() == 0) exp_q.push_back(IDLE_V);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("cycle", obs, e);
        exp_ready = e[6];
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        b0.in_valid = 1'b0;
        b1.in_valid = 1'b0;
        b2.in_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 3; s++) begin
                check("reset_outputs", obs_v[s], IDLE_V);
                check_int("reset_state", int'(st_v[s]), int'(ST_IDLE));
            end
        end
        rst = 1'b0;
        exp_ready = 1'b1;
    endtask

    task automatic drain();
        while (exp_q.size() > 0) step(1'b0, 4'h0);
        step(1'b0, 4'h0);
    endtask

    // Send one word; measure acceptance attempts, done latency and the
    // captured serial stream.
    task automatic run_word(input logic [3:0] d, input int n_bits, input logic [11:0] stream,
                            input int lat_exp, input int tries_exp, input logic noisy);
        int         tries;
        int         lat;
        int         cap_n;
        logic [11:0] cap;
        tries = 0;
        last_acc = 1'b0;
        while (!last_acc && tries < 20) begin
            step(1'b1, d);
            tries++;
        end
        check_int("accept_tries", tries, tries_exp);
        cap   = '0;
        cap_n = 0;
        lat   = 1;
        if (obs[4]) begin cap = {cap[10:0], obs[5]}; cap_n++; end
        while (!obs[0] && lat < 60) begin
            step(noisy ? 1'($urandom_range(0, 1)) : 1'b0, 4'($urandom_range(0, 15)));
            lat++;
            if (obs[4]) begin cap = {cap[10:0], obs[5]}; cap_n++; end
        end
        check_int("done_latency", lat, lat_exp);
        check_int("stream_bits", cap_n, n_bits);
        check_int("stream_value", int'(cap), int'(stream));
    endtask

    typedef struct {
        int          sel;
        logic [3:0]  data;
        int          n_bits;
        logic [11:0] stream;
        int          lat;
        int          tries;
        logic        noisy;
    } rec_t;

    rec_t tbl [7];

    initial begin
        n_vec = 0;
        n_err = 0;
        sel   = 0;
        exp_ready = 1'b1;
        b0.in_valid = 1'b0; b1.in_valid = 1'b0; b2.in_valid = 1'b0;
        b0.in_data  = '0;   b1.in_data  = '0;   b2.in_data  = '0;

        //          sel data     bits stream            lat tries noisy
        tbl[0] = '{0, 4'b1011,  4, 12'b1011,          5,  1,    1'b0};
        tbl[1] = '{0, 4'b1100,  4, 12'b1100,          5,  1,    1'b0};
        tbl[2] = '{0, 4'b0011,  4, 12'b0011,          5,  1,    1'b0}; // taken in done cycle
        tbl[3] = '{0, 4'b0101,  4, 12'b0101,          5,  1,    1'b1}; // inputs toggle while busy
        tbl[4] = '{1, 4'b1001, 12, 12'b111000000111, 13,  1,    1'b0};
        tbl[5] = '{2, 4'b1111,  4, 12'b1111,          5,  1,    1'b0};
        tbl[6] = '{2, 4'b0110,  4, 12'b0110,          5,  3,    1'b1}; // waits out the gap

        do_reset(3);

        for (int r = 0; r < 7; r++) begin
            if (tbl[r].sel != sel) begin
                drain();
                sel = tbl[r].sel;
                exp_ready = 1'b1;
            end
            run_word(tbl[r].data, tbl[r].n_bits, tbl[r].stream, tbl[r].lat, tbl[r].tries, tbl[r].noisy);
        end

        // Reset during the bit-2 period of 1010: word dropped, no done.
        drain();
        sel = 0;
        exp_ready = 1'b1;
        step(1'b1, 4'b1010);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        check("bit2_before_reset", obs, 7'b0110010);
        do_reset(1);
        for (int i = 0; i < 6; i++) step(1'b0, 4'b0000);
        run_word(4'b0110, 4, 12'b0110, 5, 1, 1'b0);

        // random traffic on every instance
        for (int s = 0; s < 3; s++) begin
            drain();
            sel = s;
            exp_ready = 1'b1;
            for (int i = 0; i < 80; i++) step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
